// File: rtl/bundle_add_cut_sequencer.sv
// ---------------------------------------------------------------------------
// bundle_add_cut_sequencer
//
// Purpose:
//   Sequencer for the FP32 element add-and-cut bundling datapath. On start it
//   walks two hypervectors A and B in a shared RAM (one read port, one write
//   port). Each element pair goes to an external pipelined fp_add_sub. Each
//   sum is clipped to [-CUT_MAG, +CUT_MAG] and written to DST in element
//   order.
//
// Ports:
//   clk, reset          clock (rising edge) / asynchronous active-high reset
//   start               run request, only honoured in IDLE
//   addr_a/b/dst [20:0] base addresses, latched when start is accepted
//   raddress    [20:0]  RAM read address (data_rd valid one clock later)
//   data_rd     [31:0]  RAM read data
//   we_n                RAM write enable, active low
//   waddress    [20:0]  RAM write address
//   data_wr     [31:0]  RAM write data
//   add_dataa/b [31:0]  registered adder operands
//   add_result  [31:0]  adder sum, ADD_LATENCY clocks after the operands
//   busy                high from accepted start until done
//   done                one-clock pulse after the last write
//   clip_count  [20:0]  number of elements clipped in the last run
//
// Build option:
//   BUNDLE_SEQ_CLIP_COUNT_EN - when defined, the clip counter is built. It is
//   cleared on an accepted start, incremented once per clipped write,
//   saturates at all-ones and holds until the next start. When undefined,
//   clip_count is tied to zero.
// ---------------------------------------------------------------------------
module bundle_add_cut_sequencer #(
  parameter int          HYPERVECTOR_DIMENSIONS = 1000,
  parameter int          NUM_KERNELS            = 1,
  parameter int          ADD_LATENCY            = 7,
  parameter logic [31:0] CUT_MAG                = 32'h3F800000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [20:0] addr_a,
  input  logic [20:0] addr_b,
  input  logic [20:0] addr_dst,
  output logic [20:0] raddress,
  input  logic [31:0] data_rd,
  output logic        we_n,
  output logic [20:0] waddress,
  output logic [31:0] data_wr,
  output logic [31:0] add_dataa,
  output logic [31:0] add_datab,
  input  logic [31:0] add_result,
  output logic        busy,
  output logic        done,
  output logic [20:0] clip_count
);

  localparam int              N       = (HYPERVECTOR_DIMENSIONS + NUM_KERNELS - 1) / NUM_KERNELS;
  localparam int              CNT_W   = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT  = CNT_W'(N);
  localparam logic [30:0]     CUT_ABS = CUT_MAG[30:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic             w_accept;
  logic             w_more;
  logic [CNT_W-1:0] w_rd_idx_inc;

  logic [20:0]      r_addr_a;
  logic [20:0]      r_addr_b;
  logic [20:0]      r_addr_dst;
  logic [20:0]      r_raddress;
  logic [CNT_W-1:0] r_rd_idx;
  logic [31:0]      r_a_data;
  logic             r_b_pending;

  logic [31:0]      r_add_a;
  logic [31:0]      r_add_b;
  logic             r_launch;
  logic [ADD_LATENCY-1:0] r_pipe;

  logic             w_result_valid;
  logic             w_clip_hit;
  logic [31:0]      w_clipped;
  logic             r_clip_v;
  logic [31:0]      r_clip_data;

  logic             r_we_n;
  logic [20:0]      r_waddress;
  logic [31:0]      r_data_wr;
  logic [CNT_W-1:0] r_wr_idx;

  assign w_rd_idx_inc = r_rd_idx + CNT_W'(1);
  assign w_more       = (w_rd_idx_inc < N_CNT);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_RD_A;
        end
      end
      S_RD_A: begin
        busy         = 1'b1;
        w_state_next = S_RD_B;
      end
      S_RD_B: begin
        busy         = 1'b1;
        w_state_next = w_more ? S_RD_A : S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // The write counter is already N while the final write is on the bus.
        if (!r_we_n && (r_wr_idx == N_CNT)) begin
          w_state_next = S_FIN;
        end
      end
      S_FIN: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- read side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_a    <= 21'd0;
      r_addr_b    <= 21'd0;
      r_addr_dst  <= 21'd0;
      r_raddress  <= 21'd0;
      r_rd_idx    <= '0;
      r_a_data    <= 32'd0;
      r_b_pending <= 1'b0;
    end else begin
      // B[i] appears on data_rd in the clock after the RD_B state.
      r_b_pending <= (r_state == S_RD_B);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr_a   <= addr_a;
            r_addr_b   <= addr_b;
            r_addr_dst <= addr_dst;
            r_raddress <= addr_a;
            r_rd_idx   <= '0;
          end
        end
        S_RD_A: begin
          r_raddress <= r_addr_b + 21'(r_rd_idx);
        end
        S_RD_B: begin
          r_a_data <= data_rd;
          if (w_more) begin
            r_rd_idx   <= w_rd_idx_inc;
            r_raddress <= r_addr_a + 21'(w_rd_idx_inc);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- adder launch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_add_a  <= 32'd0;
      r_add_b  <= 32'd0;
      r_launch <= 1'b0;
    end else begin
      r_launch <= r_b_pending;
      if (r_b_pending) begin
        r_add_a <= r_a_data;
        r_add_b <= data_rd;
      end
    end
  end

  // The launch bit travels alongside the adder so that its last stage lines
  // up with the matching add_result.
  generate
    for (genvar gi = 0; gi < ADD_LATENCY; gi++) begin : g_pipe
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_pipe[gi] <= 1'b0;
        end else if (gi == 0) begin
          r_pipe[gi] <= r_launch;
        end else begin
          r_pipe[gi] <= r_pipe[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign w_result_valid = r_pipe[ADD_LATENCY-1];

  // ---------------------------------------------------------------- clip
  // The magnitude compare on the raw bits orders all finite values correctly
  // and also catches Inf/NaN, which carry the largest exponent field.
  assign w_clip_hit = (add_result[30:0] > CUT_ABS);
  assign w_clipped  = w_clip_hit ? {add_result[31], CUT_ABS} : add_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clip_v    <= 1'b0;
      r_clip_data <= 32'd0;
    end else begin
      r_clip_v <= w_result_valid;
      if (w_result_valid) begin
        r_clip_data <= w_clipped;
      end
    end
  end

  // ---------------------------------------------------------------- write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we_n     <= 1'b1;
      r_waddress <= 21'd0;
      r_data_wr  <= 32'd0;
      r_wr_idx   <= '0;
    end else begin
      r_we_n <= ~r_clip_v;
      if (w_accept) begin
        r_wr_idx <= '0;
      end else if (r_clip_v) begin
        r_waddress <= r_addr_dst + 21'(r_wr_idx);
        r_data_wr  <= r_clip_data;
        r_wr_idx   <= r_wr_idx + CNT_W'(1);
      end
    end
  end

`ifdef BUNDLE_SEQ_CLIP_COUNT_EN
  logic        r_clip_hit;
  logic [20:0] r_clip_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clip_hit   <= 1'b0;
      r_clip_count <= 21'd0;
    end else begin
      if (w_result_valid) begin
        r_clip_hit <= w_clip_hit;
      end
      if (w_accept) begin
        r_clip_count <= 21'd0;
      end else if (r_clip_v && r_clip_hit && (r_clip_count != {21{1'b1}})) begin
        r_clip_count <= r_clip_count + 21'd1;
      end
    end
  end

  assign clip_count = r_clip_count;
`else
  assign clip_count = 21'd0;
`endif

  assign raddress  = r_raddress;
  assign add_dataa = r_add_a;
  assign add_datab = r_add_b;
  assign we_n      = r_we_n;
  assign waddress  = r_waddress;
  assign data_wr   = r_data_wr;

endmodule

// File: tb/tb_bundle_add_cut_sequencer.sv
// Testbench for bundle_add_cut_sequencer with N=4 and ADD_LATENCY=7.
// The bench uses a behavioural RAM and a behavioural pipelined FP adder.
// Stimulus pushes the expected writes and the expected done cycles into queues.
// A negedge monitor pops these entries and compares them with what the DUT presents.
module tb_bundle_add_cut_sequencer;
  localparam int L = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [20:0] addr_a, addr_b, addr_dst;
  logic [20:0] raddress, waddress, clip_count;
  logic [31:0] data_rd, data_wr, add_dataa, add_datab, add_result;
  logic        we_n, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int wr_seen = 0;

  logic [52:0] exp_q[$];
  int          done_q[$];

  logic [31:0] mem [0:(1<<21)-1];
  logic [31:0] add_pipe [0:L-1];
  logic        force_en;
  logic [31:0] force_val;

  bundle_add_cut_sequencer #(
    .HYPERVECTOR_DIMENSIONS(4),
    .NUM_KERNELS(1),
    .ADD_LATENCY(L),
    .CUT_MAG(32'h3F800000)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .addr_a(addr_a), .addr_b(addr_b), .addr_dst(addr_dst),
    .raddress(raddress), .data_rd(data_rd),
    .we_n(we_n), .waddress(waddress), .data_wr(data_wr),
    .add_dataa(add_dataa), .add_datab(add_datab), .add_result(add_result),
    .busy(busy), .done(done), .clip_count(clip_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // FP32 <-> real for normal values, signed zero and Inf/NaN
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00)      d = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF) d = {f[31], 11'h7FF, f[22:0], 29'd0};
    else                        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [7:0]  e8;
    d  = $realtobits(r);
    e8 = 8'(d[62:52] - 11'd896);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    return {d[63], e8, d[51:29]};
  endfunction

  // behavioural RAM: registered read, write when we_n low
  always @(posedge clk) begin
    data_rd <= mem[raddress];
    if (we_n == 1'b0) mem[waddress] <= data_wr;
  end

  // behavioural adder: L register stages from operands to result
  always @(posedge clk) begin
    add_pipe[0] <= force_en ? force_val : r2f(f2r(add_dataa) + f2r(add_datab));
    for (int k = 1; k < L; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_result = add_pipe[L-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=%h required=none (cycle %0d)", name, act, cyc);
  endtask

  // monitor: one line per observed write
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (we_n === 1'b0) begin
        $display("write addr=%h data=%h cycle=%0d", waddress, data_wr, cyc);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_write", {11'd0, waddress});
        end else begin
          check("write_addr", {11'd0, waddress}, {11'd0, exp_q[0][52:32]});
          check("write_data", data_wr, exp_q[0][31:0]);
          void'(exp_q.pop_front());
        end
        wr_seen <= wr_seen + 1;
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          fail_now("unexpected_done", 32'(cyc));
        end else begin
          check("done_cycle", 32'(cyc), 32'(done_q[0]));
          check("busy_at_done", {31'd0, busy}, 32'd0);
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic push_writes(input logic [20:0] dst, input logic [31:0] r0, r1, r2, r3);
    exp_q.push_back({dst,          r0});
    exp_q.push_back({dst + 21'd1,  r1});
    exp_q.push_back({dst + 21'd2,  r2});
    exp_q.push_back({dst + 21'd3,  r3});
  endtask

  // start accepted at the next posedge; done expected 19 clocks after that
  task automatic run(input logic [20:0] a, b, dst, input logic [31:0] r0, r1, r2, r3);
    @(negedge clk);
    push_writes(dst, r0, r1, r2, r3);
    done_q.push_back(cyc + 20);
    addr_a = a; addr_b = b; addr_dst = dst; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0)
      fail_now("run_timeout", 32'(exp_q.size()));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_clip(input string name, input logic [20:0] en_val);
`ifdef BUNDLE_SEQ_CLIP_COUNT_EN
    check(name, {11'd0, clip_count}, {11'd0, en_val});
`else
    check(name, {11'd0, clip_count}, 32'd0);
`endif
  endtask

  initial begin
    int n;
    int base;
    int acc;
    reset = 1'b1; start = 1'b0; force_en = 1'b0; force_val = 32'd0;
    addr_a = 21'd0; addr_b = 21'd0; addr_dst = 21'd0;
    // A={+1,-1,+1,-1} @0x100, B={+1,+1,-1,-1} @0x200
    mem[21'h100] = 32'h3F800000; mem[21'h101] = 32'hBF800000;
    mem[21'h102] = 32'h3F800000; mem[21'h103] = 32'hBF800000;
    mem[21'h200] = 32'h3F800000; mem[21'h201] = 32'h3F800000;
    mem[21'h202] = 32'hBF800000; mem[21'h203] = 32'hBF800000;
    // A={0.25,-0.75,0.5,-0.25} @0x400, B={0.5,-0.5,0.25,0.0} @0x500
    mem[21'h400] = 32'h3E800000; mem[21'h401] = 32'hBF400000;
    mem[21'h402] = 32'h3F000000; mem[21'h403] = 32'hBE800000;
    mem[21'h500] = 32'h3F000000; mem[21'h501] = 32'hBF000000;
    mem[21'h502] = 32'h3E800000; mem[21'h503] = 32'h00000000;
    // wrap vector A={0.5,0.25,-0.5,0.0} @1FFFFE.., B={0.25,-0.5,0.25,-1.0} @0x700
    mem[21'h1FFFFE] = 32'h3F000000; mem[21'h1FFFFF] = 32'h3E800000;
    mem[21'h000000] = 32'hBF000000; mem[21'h000001] = 32'h00000000;
    mem[21'h700] = 32'h3E800000; mem[21'h701] = 32'hBF000000;
    mem[21'h702] = 32'h3E800000; mem[21'h703] = 32'hBF800000;

    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_we_n",  {31'd0, we_n}, 32'd1);
    check("rst_raddr", {11'd0, raddress}, 32'd0);
    check("rst_waddr", {11'd0, waddress}, 32'd0);
    check("rst_data_wr", data_wr, 32'd0);
    check("rst_dataa", add_dataa, 32'd0);
    check("rst_datab", add_datab, 32'd0);
    check("rst_clip",  {11'd0, clip_count}, 32'd0);
    reset = 1'b0;

    // basic bipolar bundle with +/-2 clipped
    run(21'h100, 21'h200, 21'h300, 32'h3F800000, 32'h00000000, 32'h00000000, 32'hBF800000);
    wait_idle();
    check_clip("clip_t1", 21'd2);

    // fractional values, one clip
    run(21'h400, 21'h500, 21'h600, 32'h3F400000, 32'hBF800000, 32'h3F400000, 32'hBE800000);
    wait_idle();
    check_clip("clip_t2", 21'd1);
    repeat (5) @(negedge clk);
    check_clip("clip_t2_held", 21'd1);

    // +Inf from adder, plus a start pulse while busy that must be ignored
    force_en = 1'b1; force_val = 32'h7F800000;
    run(21'h100, 21'h200, 21'hB00, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    repeat (2) @(negedge clk);
    check("busy_midrun", {31'd0, busy}, 32'd1);
    addr_a = 21'h050; addr_b = 21'h060; addr_dst = 21'h070; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check_clip("clip_inf", 21'd4);

    // negative NaN keeps its sign
    force_val = 32'hFFC00000;
    run(21'h100, 21'h200, 21'hC00, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000);
    wait_idle();
    check_clip("clip_nan", 21'd4);

    // -0.0 passes unchanged
    force_val = 32'h80000000;
    run(21'h100, 21'h200, 21'hD00, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000);
    wait_idle();
    check_clip("clip_negzero", 21'd0);
    force_en = 1'b0;

    // address wrap with in-place destination; last element equals -1.0 exactly
    run(21'h1FFFFE, 21'h700, 21'h1FFFFE, 32'h3F400000, 32'hBE800000, 32'hBE800000, 32'hBF800000);
    wait_idle();
    check_clip("clip_wrap", 21'd0);

    // reset during the third write of a run
    base = wr_seen;
    run(21'h100, 21'h200, 21'h800, 32'h3F800000, 32'h00000000, 32'h00000000, 32'hBF800000);
    n = 0;
    while (wr_seen < base + 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (wr_seen < base + 2) fail_now("reset_wait_timeout", 32'(wr_seen - base));
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("async_rst_we_n", {31'd0, we_n}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_waddr", {11'd0, waddress}, 32'd0);
    check("pending_after_abort", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    run(21'h100, 21'h200, 21'h900, 32'h3F800000, 32'h00000000, 32'h00000000, 32'hBF800000);
    wait_idle();

    // start held high: second run accepted in the clock after done
    @(negedge clk);
    acc = cyc + 1;
    push_writes(21'hA00, 32'h3F400000, 32'hBF800000, 32'h3F400000, 32'hBE800000);
    push_writes(21'hA00, 32'h3F400000, 32'hBF800000, 32'h3F400000, 32'hBE800000);
    done_q.push_back(acc + 19);
    done_q.push_back(acc + 40);
    addr_a = 21'h400; addr_b = 21'h500; addr_dst = 21'hA00; start = 1'b1;
    n = 0;
    while (cyc < acc + 21 && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    wait_idle();
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
